// File: rtl/axi_addr_ch_rx.sv
// axi_addr_ch_rx: buffers AXI address beats, translates each head address, then hands it to the transmit stage in order.
// Define AXI_ADDR_RX_FAULT_EN to add translation fault reporting (xl_fault / fault_valid / fault_addr / fault_id).
module axi_addr_ch_rx #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic [3:0]  in_id,
  input  logic [31:0] in_addr,
  input  logic [7:0]  in_len,
  input  logic [2:0]  in_size,
  input  logic [1:0]  in_burst,
  input  logic [2:0]  in_prot,
  input  logic [3:0]  in_cache,
  input  logic [1:0]  in_user,
  input  logic        in_lock,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] virt_addr,
  output logic        xl_req,
  input  logic        xl_done,
  input  logic [31:0] xl_phy_addr,
  output logic [3:0]  out_id,
  output logic [7:0]  out_len,
  output logic [2:0]  out_size,
  output logic [1:0]  out_burst,
  output logic [2:0]  out_prot,
  output logic [3:0]  out_cache,
  output logic [1:0]  out_user,
  output logic        out_lock,
  output logic [31:0] phy_addr,
  output logic        t_done,
  input  logic        tx_busy
`ifdef AXI_ADDR_RX_FAULT_EN
  ,
  input  logic        xl_fault,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic [3:0]  fault_id
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 59;
  typedef enum logic [1:0] {IDLE, XLATE, DELIVER} state_t;
  state_t r_state, w_state_nxt;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count, w_count_nxt;
  logic [31:0]   r_phy_addr;
  logic          w_push, w_pop, w_fault;
  assign {out_id, virt_addr, out_len, out_size, out_burst, out_prot, out_cache, out_user, out_lock} = r_mem[r_rd_ptr];
  assign in_ready = ~reset & (r_count != (PW+1)'(FIFO_DEPTH));
  assign w_push = in_valid & in_ready;
  assign xl_req = ~reset & (r_state == XLATE);
  assign t_done = ~reset & (r_state == DELIVER) & ~tx_busy;
`ifdef AXI_ADDR_RX_FAULT_EN
  assign w_fault = xl_req & xl_done & xl_fault;
`else
  assign w_fault = 1'b0;
`endif
  assign w_pop = t_done | w_fault;
  assign w_count_nxt = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
  assign phy_addr = r_phy_addr;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = (w_count_nxt != '0) ? XLATE : IDLE;
      XLATE:   if (xl_done) w_state_nxt = w_fault ? ((w_count_nxt != '0) ? XLATE : IDLE) : DELIVER;
      DELIVER: if (t_done) w_state_nxt = (w_count_nxt != '0) ? XLATE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge rx_clk)
    if (w_push) r_mem[r_wr_ptr] <= {in_id, in_addr, in_len, in_size, in_burst, in_prot, in_cache, in_user, in_lock};
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_phy_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (xl_req & xl_done & ~w_fault) r_phy_addr <= xl_phy_addr;
    end
  end
`ifdef AXI_ADDR_RX_FAULT_EN
  logic        r_fault_valid;
  logic [31:0] r_fault_addr;
  logic [3:0]  r_fault_id;
  assign fault_valid = r_fault_valid;
  assign fault_addr  = r_fault_addr;
  assign fault_id    = r_fault_id;
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
      r_fault_id    <= '0;
    end else begin
      r_fault_valid <= w_fault;
      if (w_fault) begin
        r_fault_addr <= virt_addr;
        r_fault_id   <= out_id;
      end
    end
  end
`endif
endmodule
